// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
//   Hands the shared tri-state data bus to one of p_MASTERS masters (CPU data
//   side, DMA, debug port, ...). Round-robin selection, bounded ownership
//   quantum with a per-master lock override, and optional zero-grant
//   turnaround cycles between two different owners so that bus drivers never
//   overlap.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Rst         asynchronous active-high reset
//   i_Req         per-master request, held while the master needs the bus
//   i_Lock        per-master lock, suppresses quantum preemption of the owner
//   o_Gnt         registered one-hot (or zero) grant
//   o_GntValid    registered OR of o_Gnt
//   o_GntIdx      index of the current/last owner
//   o_Turnaround  high during inserted zero-grant cycles
// -----------------------------------------------------------------------------
module dbus_arbiter #(
    parameter int p_MASTERS    = 3,
    parameter int p_IDX_W      = 2,
    parameter int p_QUANTUM    = 16,
    parameter int p_TURNAROUND = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [p_MASTERS-1:0] i_Req,
    input  logic [p_MASTERS-1:0] i_Lock,
    output logic [p_MASTERS-1:0] o_Gnt,
    output logic                 o_GntValid,
    output logic [p_IDX_W-1:0]   o_GntIdx,
    output logic                 o_Turnaround
);

    localparam int CNT_W = (p_QUANTUM < 1) ? 1 : $clog2(p_QUANTUM + 1);
    localparam logic [CNT_W-1:0] c_QMAX  = CNT_W'(p_QUANTUM);
    localparam logic [CNT_W-1:0] c_QLAST = CNT_W'((p_QUANTUM > 0) ? p_QUANTUM - 1 : 0);
    localparam logic [1:0]       c_TA_LAST = 2'((p_TURNAROUND > 0) ? p_TURNAROUND - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t               r_State;
    logic [p_MASTERS-1:0] r_Gnt;
    logic                 r_GntValid;
    logic [p_IDX_W-1:0]   r_GntIdx;
    logic [p_IDX_W-1:0]   r_Ptr;
    logic [CNT_W-1:0]     r_Cnt;
    logic [1:0]           r_TurnCnt;
    logic                 r_Turnaround;

    state_t               w_NextState;
    logic [p_MASTERS-1:0] w_NextGnt;
    logic [p_IDX_W-1:0]   w_NextIdx;
    logic [p_IDX_W-1:0]   w_NextPtr;
    logic [CNT_W-1:0]     w_NextCnt;
    logic [1:0]           w_NextTurnCnt;
    logic                 w_NextTurnaround;
    logic                 w_DoGrant;

    logic [p_MASTERS-1:0] w_Others;
    logic                 w_OwnerReq;
    logic                 w_OwnerLock;
    logic                 w_QuantumHit;
    logic                 w_Leave;
    logic [p_MASTERS-1:0] w_PickReq;
    logic [p_IDX_W:0]     w_Pick;
    logic                 w_PickFound;
    logic [p_IDX_W-1:0]   w_PickIdx;
    logic [p_MASTERS-1:0] w_WinOneHot;
    logic [p_IDX_W-1:0]   w_PtrAfter;

    // Round-robin search: rotate the request vector so the pointer position
    // lands on bit 0, take the lowest set bit, then rotate the index back.
    // Returns {found, index}.
    function automatic logic [p_IDX_W:0] f_RrPick(
        input logic [p_MASTERS-1:0] i_ReqV,
        input logic [p_IDX_W-1:0]   i_PtrV
    );
        logic [2*p_MASTERS-1:0] w_Dbl;
        logic [p_IDX_W:0]       w_Sum;
        logic [p_IDX_W:0]       w_Res;
        w_Dbl = {i_ReqV, i_ReqV} >> i_PtrV;
        w_Sum = '0;
        w_Res = '0;
        for (int i = p_MASTERS - 1; i >= 0; i--) begin
            if (w_Dbl[i]) begin
                w_Sum = {1'b0, i_PtrV} + (p_IDX_W+1)'(i);
                if (w_Sum >= (p_IDX_W+1)'(p_MASTERS))
                    w_Sum = w_Sum - (p_IDX_W+1)'(p_MASTERS);
                w_Res = {1'b1, w_Sum[p_IDX_W-1:0]};
            end
        end
        return w_Res;
    endfunction

    // While granted, r_Gnt is the owner's one-hot mask.
    assign w_Others     = i_Req & ~r_Gnt;
    assign w_OwnerReq   = |(i_Req & r_Gnt);
    assign w_OwnerLock  = |(i_Lock & r_Gnt);
    // The counter saturates at p_QUANTUM, so ">=" also catches a waiter that
    // shows up (or a lock that drops) after the quantum already ran out.
    assign w_QuantumHit = (p_QUANTUM != 0) && (r_Cnt >= c_QLAST);
    assign w_Leave      = !w_OwnerReq || (w_QuantumHit && !w_OwnerLock && (|w_Others));

    // The old owner is excluded only on a direct hand-over out of GRANT.
    assign w_PickReq   = (r_State == S_GRANT) ? w_Others : i_Req;
    assign w_Pick      = f_RrPick(w_PickReq, r_Ptr);
    assign w_PickFound = w_Pick[p_IDX_W];
    assign w_PickIdx   = w_Pick[p_IDX_W-1:0];
    assign w_WinOneHot = {{(p_MASTERS-1){1'b0}}, 1'b1} << w_PickIdx;
    assign w_PtrAfter  = (w_PickIdx == p_IDX_W'(p_MASTERS - 1)) ? '0 : w_PickIdx + 1'b1;

    always_comb begin
        w_NextState      = r_State;
        w_NextGnt        = r_Gnt;
        w_NextIdx        = r_GntIdx;
        w_NextPtr        = r_Ptr;
        w_NextCnt        = r_Cnt;
        w_NextTurnCnt    = r_TurnCnt;
        w_NextTurnaround = 1'b0;
        w_DoGrant        = 1'b0;

        case (r_State)
            S_IDLE: begin
                if (w_PickFound)
                    w_DoGrant = 1'b1;
            end
            S_GRANT: begin
                if (r_Cnt != c_QMAX)
                    w_NextCnt = r_Cnt + 1'b1;
                if (w_Leave) begin
                    w_NextGnt = '0;
                    if (!(|w_Others)) begin
                        w_NextState = S_IDLE;
                    end else if (p_TURNAROUND > 0) begin
                        w_NextState      = S_TURN;
                        w_NextTurnCnt    = c_TA_LAST;
                        w_NextTurnaround = 1'b1;
                    end else begin
                        w_DoGrant = 1'b1;
                    end
                end
            end
            S_TURN: begin
                if (r_TurnCnt == '0) begin
                    if (w_PickFound)
                        w_DoGrant = 1'b1;
                    else
                        w_NextState = S_IDLE;
                end else begin
                    w_NextTurnCnt    = r_TurnCnt - 1'b1;
                    w_NextTurnaround = 1'b1;
                end
            end
            default: begin
                w_NextState = S_IDLE;
                w_NextGnt   = '0;
            end
        endcase

        if (w_DoGrant) begin
            w_NextState = S_GRANT;
            w_NextGnt   = w_WinOneHot;
            w_NextIdx   = w_PickIdx;
            w_NextPtr   = w_PtrAfter;
            w_NextCnt   = '0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State      <= S_IDLE;
            r_Gnt        <= '0;
            r_GntValid   <= 1'b0;
            r_GntIdx     <= '0;
            r_Ptr        <= '0;
            r_Cnt        <= '0;
            r_TurnCnt    <= '0;
            r_Turnaround <= 1'b0;
        end else begin
            r_State      <= w_NextState;
            r_Gnt        <= w_NextGnt;
            r_GntValid   <= |w_NextGnt;
            r_GntIdx     <= w_NextIdx;
            r_Ptr        <= w_NextPtr;
            r_Cnt        <= w_NextCnt;
            r_TurnCnt    <= w_NextTurnCnt;
            r_Turnaround <= w_NextTurnaround;
        end
    end

    assign o_Gnt        = r_Gnt;
    assign o_GntValid   = r_GntValid;
    assign o_GntIdx     = r_GntIdx;
    assign o_Turnaround = r_Turnaround;

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the tri-stated data bus between up to N bus masters: CPU data-side master, DMA engine, debug port.
- Drives the per-master bus grant inputs. Only the granted master drives address, byte-enable, read, write and write-data; all others float.
- Round-robin arbitration with a bounded ownership quantum and a lock override.
- Inserts bus turnaround cycles whenever ownership changes, so two masters never drive the bus in the same cycle.

Parameters:
- p_MASTERS, 3, number of requesting masters (2..8).
- p_IDX_W, 2, width of the grant index; must equal ceil(log2(p_MASTERS)).
- p_QUANTUM, 16, maximum consecutive owned cycles while another master is waiting; 0 disables preemption.
- p_TURNAROUND, 1, zero-grant cycles inserted between two different owners (0..3).

Ports:
- i_Clk  in  1  system clock, all state on rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Req  in  p_MASTERS  per-master request; held high for as long as the master needs the bus.
- i_Lock  in  p_MASTERS  per-master lock; blocks quantum preemption of that master while it owns the bus.
- o_Gnt  out  p_MASTERS  one-hot (or zero) grant; bit k drives master k's bus grant input.
- o_GntValid  out  1  OR of o_Gnt.
- o_GntIdx  out  p_IDX_W  index of current owner; holds the last owner while o_GntValid=0.
- o_Turnaround  out  1  high during inserted zero-grant cycles.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_Gnt=0; o_GntValid=0; o_GntIdx=0; o_Turnaround=0; RR pointer=0; quantum counter=0.
- All outputs are registered. o_Gnt is never multi-hot, in any state.
- RR select: search the requests starting at index (pointer) and wrapping. On every new grant, pointer <= granted index + 1, wrapping at p_MASTERS.
- IDLE:
  - Any i_Req high -> next edge: o_Gnt = one-hot of the RR winner, counter=0, state=GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT:
  - Counter increments each cycle, saturating at p_QUANTUM.
  - Release: i_Req[owner]=0 -> next edge o_Gnt=0. The owner must finish its transaction before dropping i_Req.
  - Preempt: p_QUANTUM!=0, counter==p_QUANTUM-1, i_Lock[owner]=0, and any other i_Req high -> next edge o_Gnt=0.
  - Lock held: no preemption regardless of counter. When the lock drops with counter saturated and a waiter present, preempt on the next edge.
- Leaving GRANT (release or preempt):
  - If p_TURNAROUND>0 and any request other than the old owner is pending: state=TURN, o_Turnaround=1 for exactly p_TURNAROUND cycles, then select by RR from i_Req sampled in the last TURN cycle.
  - If p_TURNAROUND=0: the new one-hot grant is loaded on the same edge the old grant drops; no zero cycle.
  - If no requests are pending: state=IDLE, o_Gnt=0, no TURN.
- TURN end:
  - If no i_Req is high -> IDLE.
  - A request that drops during TURN is not granted.
- Re-request: a released owner that re-asserts i_Req competes via RR. Because the pointer has advanced past it, all waiting masters are served first.
- Preempted owner: keeps i_Req high and is re-granted on its next RR turn. Counter resets on every new grant.
- Simultaneous release and new request from the same owner in one cycle: treated as release.
- Reset mid-grant: o_Gnt clears immediately (asynchronously); no turnaround is inserted after reset release.

Test Plan:
- Single requester: i_Req=001 at cycle 0 -> o_Gnt=001 and o_GntIdx=0 at cycle 1. Drop i_Req at cycle 5 -> o_Gnt=000 at cycle 6, state IDLE, o_Turnaround never asserted.
- Round robin: i_Req=111 held, each master drops its request 4 cycles after its grant (p_TURNAROUND=1) -> grant order 0,1,2. Exactly one o_Turnaround cycle between owners; o_Gnt never multi-hot.
- Preemption: master 0 granted and holds i_Req; master 2 requests; p_QUANTUM=16 -> master 0 owns exactly 16 cycles, then 1 turnaround cycle, then o_Gnt=100.
- Lock: same as the preemption case with i_Lock[0]=1 for 40 cycles -> master 0 owns for 40 cycles. The lock drops -> o_Gnt=000 on the next edge, master 2 granted after the turnaround.
- p_TURNAROUND=0: master 1 releases while master 0 waits -> o_Gnt goes 010 to 001 on one edge, with no zero cycle.
- Async reset asserted mid-grant (o_Gnt=010) -> o_Gnt=000 within the same cycle. After reset release, i_Req=110 -> o_Gnt=010 (pointer=0, first requester from index 0 is 1).
